// File: rtl/sos_pkg.sv
// Shared types and constants for the S-O-S sequencer: state encoding, letter codes
// and the fixed S,O,S letter table.
package sos_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LETTER = 3'd1,
        ST_GAP    = 3'd2,
        ST_WGAP   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic {
        L_S = 1'b0,
        L_O = 1'b1
    } letter_t;

    localparam logic [1:0]  LAST_IDX = 2'd2;
    localparam logic [16:0] T1MS_DEF = 17'd49_999;

    // Letter table: idx0 = S, idx1 = O, idx2 = S. idx3 never occurs.
    function automatic letter_t letter_at(input logic [1:0] idx);
        case (idx)
            2'd1:    letter_at = L_O;
            default: letter_at = L_S;
        endcase
    endfunction

endpackage

// File: rtl/sos_seq_ctrl_ms_timer.sv
// Millisecond timer for the sequencer gaps: a tick prescaler (0..T1MS) feeding a
// saturating 10-bit ms counter. clr has priority over en.
module ms_timer
    import sos_pkg::*;
#(
    parameter logic [16:0] T1MS = T1MS_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       clr,
    input  logic       en,
    output logic       tick,
    output logic [9:0] ms_cnt
);

    logic [16:0] tick_cnt;

    assign tick = en && (tick_cnt == T1MS);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick_cnt <= '0;
            ms_cnt   <= '0;
        end else if (clr) begin
            tick_cnt <= '0;
            ms_cnt   <= '0;
        end else if (en) begin
            if (tick) begin
                tick_cnt <= '0;
                if (ms_cnt != 10'h3FF) begin
                    ms_cnt <= ms_cnt + 10'd1;
                end
            end else begin
                tick_cnt <= tick_cnt + 17'd1;
            end
        end
    end

endmodule

// File: rtl/sos_seq_ctrl.sv
// S-O-S word sequencer: launches the letter generators in table order, times the gaps,
// repeats the word and muxes the active generator's pin onto Pin_Out.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_IDLE   | waiting for Start_Sig (Stop_Sig blocks it), stop_pend cleared
//  ST_LETTER | start of table[idx] held high until that generator's Done
//  ST_GAP    | inter-letter gap, GAP_MS
//  ST_WGAP   | inter-word gap, WGAP_MS
//  ST_DONE   | one-cycle Done_Sig after the last letter of the last word
module sos_seq_ctrl
    import sos_pkg::*;
#(
    parameter logic [16:0] T1MS    = T1MS_DEF,
    parameter logic [9:0]  GAP_MS  = 10'd150,
    parameter logic [9:0]  WGAP_MS = 10'd350,
    parameter logic [3:0]  REPEAT  = 4'd3
) (
    input  logic CLK,
    input  logic RST,
    input  logic Start_Sig,
    input  logic Stop_Sig,
    input  logic S_Done_Sig,
    input  logic O_Done_Sig,
    input  logic S_Pin_In,
    input  logic O_Pin_In,
    output logic S_Start_Sig,
    output logic O_Start_Sig,
    output logic Busy_Sig,
    output logic Done_Sig,
    output logic Pin_Out
);

    state_t      state, state_d;
    logic [1:0]  idx, idx_d;
    logic [3:0]  word, word_d;
    logic        stop_pend, stop_pend_d;
    logic        s_start_d, o_start_d;
    letter_t     sel;
    logic        sel_done;
    logic        last_word;
    logic        in_gap;
    logic        gap_exit;
    logic [9:0]  gap_lim;
    logic [9:0]  ms_cnt;
    logic        gap_tick_unused;

    assign sel       = letter_at(idx);
    assign sel_done  = (sel == L_S) ? S_Done_Sig : O_Done_Sig;
    assign last_word = (REPEAT != 4'd0) && (word == REPEAT - 4'd1);
    assign in_gap    = (state == ST_GAP) || (state == ST_WGAP);
    assign gap_lim   = (state == ST_WGAP) ? WGAP_MS : GAP_MS;
    assign gap_exit  = (ms_cnt == gap_lim);

    // Timer is held clear outside the gap states, so every gap starts from zero.
    // Gap exit keys on the ms count directly; the per-ms strobe is not needed here.
    ms_timer #(
        .T1MS (T1MS)
    ) u_gap_timer (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (!in_gap),
        .en     (in_gap),
        .tick   (gap_tick_unused),
        .ms_cnt (ms_cnt)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            idx         <= '0;
            word        <= '0;
            stop_pend   <= 1'b0;
            S_Start_Sig <= 1'b0;
            O_Start_Sig <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            word        <= word_d;
            stop_pend   <= stop_pend_d;
            S_Start_Sig <= s_start_d;
            O_Start_Sig <= o_start_d;
        end
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        word_d      = word;
        stop_pend_d = stop_pend;

        unique case (state)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (Start_Sig && !Stop_Sig) begin
                    state_d = ST_LETTER;
                    idx_d   = 2'd0;
                    word_d  = 4'd0;
                end
            end
            ST_LETTER: begin
                // A letter in flight cannot be cancelled; a stop only takes effect at its Done.
                if (Stop_Sig) begin
                    stop_pend_d = 1'b1;
                end
                if (sel_done) begin
                    if (stop_pend || Stop_Sig) begin
                        state_d     = ST_IDLE;
                        stop_pend_d = 1'b0;
                    end else if (idx == LAST_IDX) begin
                        if (last_word) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_WGAP;
                            idx_d   = 2'd0;
                            if (word != 4'hF) begin
                                word_d = word + 4'd1;
                            end
                        end
                    end else begin
                        state_d = ST_GAP;
                        idx_d   = idx + 2'd1;
                    end
                end
            end
            ST_GAP, ST_WGAP: begin
                if (Stop_Sig) begin
                    state_d = ST_IDLE;
                end else if (gap_exit) begin
                    state_d = ST_LETTER;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Starts are registered from the next state so they drop on the edge that leaves LETTER.
        s_start_d = (state_d == ST_LETTER) && (letter_at(idx_d) == L_S);
        o_start_d = (state_d == ST_LETTER) && (letter_at(idx_d) == L_O);
    end

    assign Busy_Sig = (state != ST_IDLE);
    assign Done_Sig = (state == ST_DONE);
    assign Pin_Out  = (state == ST_LETTER) ? ((sel == L_S) ? S_Pin_In : O_Pin_In) : 1'b1;

endmodule

// File: tb/tb_sos_seq_ctrl.sv
// Bench for sos_seq_ctrl: two instances (REPEAT=2 and REPEAT=0) driven by stub letter
// generators, checked every cycle against a position/countdown model of the run.
module tb_sos_seq_ctrl;

    localparam logic [16:0] T1MS     = 17'd9;
    localparam logic [9:0]  GAP_MS   = 10'd3;
    localparam logic [9:0]  WGAP_MS  = 10'd5;
    localparam int          DONE_DLY = 20;
    localparam int          GAP_CYC  = int'(GAP_MS) * (int'(T1MS) + 1) + 1;
    localparam int          WGAP_CYC = int'(WGAP_MS) * (int'(T1MS) + 1) + 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic s_pin = 1'b1;
    logic o_pin = 1'b1;
    logic s_done [2] = '{1'b0, 1'b0};
    logic o_done [2] = '{1'b0, 1'b0};
    logic s_start [2];
    logic o_start [2];
    logic busy [2];
    logic done [2];
    logic pin [2];

    int n_chk = 0;
    int n_pass = 0;

    // model: flat letter position within the run, plus a cycle countdown while in a gap
    bit m_busy [2], m_done [2], m_gap [2], m_pend [2];
    int m_pos [2], m_left [2];
    // stub generators
    int s_cnt [2], o_cnt [2];
    bit s_fired [2], o_fired [2];
    bit spur_en = 1'b0;
    // observation logs
    int launch_q [$];
    int gap_q [$];
    int launch_cnt [2], done_cnt [2];
    bit prev_act [2];
    bit had_fall;
    int gap_run;
    bit exp_l;
    bit act;
    bit sd [2], od [2];
    int t1_seq [6] = '{0, 1, 0, 0, 1, 0};
    int t1_gap [5] = '{GAP_CYC, GAP_CYC, WGAP_CYC, GAP_CYC, GAP_CYC};

    sos_seq_ctrl #(.T1MS(T1MS), .GAP_MS(GAP_MS), .WGAP_MS(WGAP_MS), .REPEAT(4'd2)) dut_r2 (
        .CLK(CLK), .RST(RST), .Start_Sig(start), .Stop_Sig(stop),
        .S_Done_Sig(s_done[0]), .O_Done_Sig(o_done[0]), .S_Pin_In(s_pin), .O_Pin_In(o_pin),
        .S_Start_Sig(s_start[0]), .O_Start_Sig(o_start[0]), .Busy_Sig(busy[0]),
        .Done_Sig(done[0]), .Pin_Out(pin[0]));

    sos_seq_ctrl #(.T1MS(T1MS), .GAP_MS(GAP_MS), .WGAP_MS(WGAP_MS), .REPEAT(4'd0)) dut_r0 (
        .CLK(CLK), .RST(RST), .Start_Sig(start), .Stop_Sig(stop),
        .S_Done_Sig(s_done[1]), .O_Done_Sig(o_done[1]), .S_Pin_In(s_pin), .O_Pin_In(o_pin),
        .S_Start_Sig(s_start[1]), .O_Start_Sig(o_start[1]), .Busy_Sig(busy[1]),
        .Done_Sig(done[1]), .Pin_Out(pin[1]));

    initial forever #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", name, inst, got, exp, $time);
    endtask

    function automatic bit is_o(input int pos);
        return (pos % 3) == 1;
    endfunction

    function automatic int last_pos(input int i);
        return (i == 0) ? 5 : -1;
    endfunction

    task automatic model_reset(input int i);
        m_busy[i] = 0; m_done[i] = 0; m_gap[i] = 0; m_pend[i] = 0; m_pos[i] = 0; m_left[i] = 0;
        s_cnt[i] = 0; o_cnt[i] = 0; s_fired[i] = 0; o_fired[i] = 0;
    endtask

    task automatic model_step(input int i, input bit sdn, input bit odn);
        bit seld;
        if (!m_busy[i]) begin
            m_pend[i] = 0;
            if (start && !stop) begin
                m_busy[i] = 1; m_pos[i] = 0; m_gap[i] = 0; m_done[i] = 0;
            end
        end else if (m_done[i]) begin
            m_done[i] = 0; m_busy[i] = 0;
        end else if (m_gap[i]) begin
            if (stop) begin
                m_busy[i] = 0; m_gap[i] = 0;
            end else begin
                m_left[i]--;
                if (m_left[i] == 0) m_gap[i] = 0;
            end
        end else begin
            seld = is_o(m_pos[i]) ? odn : sdn;
            if (seld) begin
                if (m_pend[i] || stop) begin
                    m_busy[i] = 0; m_pend[i] = 0;
                end else if (m_pos[i] == last_pos(i)) begin
                    m_done[i] = 1;
                end else begin
                    m_left[i] = (m_pos[i] % 3 == 2) ? WGAP_CYC : GAP_CYC;
                    m_gap[i] = 1;
                    m_pos[i]++;
                end
            end else if (stop) begin
                m_pend[i] = 1;
            end
        end
    endtask

    // compare process: check outputs, log events, then drive next stub/pin inputs and step model
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (RST) model_reset(i);
            exp_l = m_busy[i] && !m_done[i] && !m_gap[i];
            chk("busy", i, busy[i], m_busy[i]);
            chk("done", i, done[i], m_done[i]);
            chk("s_start", i, s_start[i], exp_l && !is_o(m_pos[i]));
            chk("o_start", i, o_start[i], exp_l && is_o(m_pos[i]));
            chk("pin_out", i, pin[i], exp_l ? (is_o(m_pos[i]) ? o_pin : s_pin) : 1'b1);

            act = s_start[i] | o_start[i];
            if (act && !prev_act[i]) launch_cnt[i]++;
            if (done[i]) done_cnt[i]++;
            if (i == 0) begin
                if (act && !prev_act[0]) begin
                    launch_q.push_back(int'(o_start[0]));
                    if (had_fall) gap_q.push_back(gap_run);
                    had_fall = 0;
                end else if (!act && prev_act[0]) begin
                    had_fall = busy[0];
                    gap_run = 1;
                end else if (!act && had_fall) begin
                    gap_run++;
                end
                if (!busy[0]) had_fall = 0;
            end
            prev_act[i] = act;
        end

        for (int i = 0; i < 2; i++) begin
            sd[i] = 0; od[i] = 0;
            if (!RST) begin
                if (s_start[i]) begin
                    if (!s_fired[i]) begin
                        s_cnt[i]++;
                        if (s_cnt[i] == DONE_DLY) begin sd[i] = 1; s_fired[i] = 1; end
                    end
                end else begin
                    s_cnt[i] = 0; s_fired[i] = 0;
                end
                if (o_start[i]) begin
                    if (!o_fired[i]) begin
                        o_cnt[i]++;
                        if (o_cnt[i] == DONE_DLY) begin od[i] = 1; o_fired[i] = 1; end
                    end
                end else begin
                    o_cnt[i] = 0; o_fired[i] = 0;
                end
                if (spur_en && m_busy[i] && !m_done[i] && !m_gap[i] && $urandom_range(0, 5) == 0) begin
                    if (is_o(m_pos[i])) sd[i] = 1;
                    else od[i] = 1;
                end
                model_step(i, sd[i], od[i]);
            end
            s_done[i] = sd[i];
            o_done[i] = od[i];
        end
        s_pin = 1'($urandom_range(0, 1));
        o_pin = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_logs();
        launch_q.delete();
        gap_q.delete();
        for (int i = 0; i < 2; i++) begin launch_cnt[i] = 0; done_cnt[i] = 0; end
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic wait_idle0(input int lim, input string name);
        int n = 0;
        while (busy[0] && n < lim) begin tick(); n++; end
        chk(name, 0, n < lim, 1);
    endtask

    task automatic stop_all(input string name);
        int n = 0;
        start = 0; stop = 1;
        while ((busy[0] || busy[1]) && n < 300) begin tick(); n++; end
        chk(name, 0, n < 300, 1);
        tick(); stop = 0; tick();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk("rst_busy", 0, busy[0], 0);
        chk("rst_pin", 0, pin[0], 1);
        RST = 0;
        repeat (2) tick();

        // run of two words, no interference
        clear_logs();
        pulse_start();
        wait_idle0(3000, "t1_timeout");
        chk("t1_launches", 0, launch_q.size(), 6);
        for (int k = 0; k < launch_q.size() && k < 6; k++) chk("t1_letter", k, launch_q[k], t1_seq[k]);
        chk("t1_gaps", 0, gap_q.size(), 5);
        for (int k = 0; k < gap_q.size() && k < 5; k++) chk("t1_gap_len", k, gap_q[k], t1_gap[k]);
        chk("t1_done_pulses", 0, done_cnt[0], 1);
        stop_all("t1_stop_timeout");

        // stop during an inter-letter gap
        clear_logs();
        pulse_start();
        n = 0;
        while (!(busy[0] && !s_start[0] && !o_start[0] && !done[0]) && n < 200) begin tick(); n++; end
        chk("t3_gap_timeout", 0, n < 200, 1);
        repeat ($urandom_range(0, 20)) tick();
        stop = 1; tick(); stop = 0;
        chk("t3_busy", 0, busy[0], 0);
        chk("t3_starts", 0, {s_start[0], o_start[0]}, 0);
        repeat (5) tick();
        chk("t3_no_done", 0, done_cnt[0], 0);
        stop_all("t3_stop_timeout");

        // stop while O is being sent
        clear_logs();
        pulse_start();
        n = 0;
        while (!o_start[0] && n < 200) begin tick(); n++; end
        chk("t4_o_timeout", 0, n < 200, 1);
        repeat (5) tick();
        stop = 1; tick(); stop = 0;
        chk("t4_o_held", 0, o_start[0], 1);
        n = 0;
        while ((busy[0] || busy[1]) && n < 100) begin tick(); n++; end
        chk("t4_idle_timeout", 0, n < 100, 1);
        chk("t4_launches", 0, launch_cnt[0], 2);
        chk("t4_no_done", 0, done_cnt[0], 0);
        stop_all("t4_stop_timeout");

        // spurious non-selected dones, continuous instance keeps going
        spur_en = 1;
        clear_logs();
        pulse_start();
        n = 0;
        while (launch_cnt[1] < 15 && n < 4000) begin tick(); n++; end
        chk("t5_cont_timeout", 1, n < 4000, 1);
        chk("t5_cont_no_done", 1, done_cnt[1], 0);
        chk("t5_r2_launches", 0, launch_cnt[0], 6);
        chk("t5_r2_done", 0, done_cnt[0], 1);
        stop_all("t5_stop_timeout");
        spur_en = 0;

        // reset in the middle of a letter, then restart from the first S
        clear_logs();
        pulse_start();
        n = 0;
        while (!s_start[0] && n < 50) begin tick(); n++; end
        chk("t6_s_timeout", 0, n < 50, 1);
        repeat (3) tick();
        RST = 1;
        #1;
        chk("t6_busy", 0, busy[0], 0);
        chk("t6_s_start", 0, s_start[0], 0);
        chk("t6_pin", 0, pin[0], 1);
        tick(); RST = 0; tick();
        clear_logs();
        pulse_start();
        wait_idle0(3000, "t6_run_timeout");
        chk("t6_first_letter", 0, (launch_q.size() > 0) ? launch_q[0] : -1, 0);
        chk("t6_launches", 0, launch_q.size(), 6);
        chk("t6_done", 0, done_cnt[0], 1);
        stop_all("t6_stop_timeout");

        // randomized runs with stray starts, stops and spurious dones
        spur_en = 1;
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 5)) tick();
            stop = ($urandom_range(0, 3) == 0);
            start = 1;
            repeat ($urandom_range(1, 3)) tick();
            start = 0; stop = 0;
            n = $urandom_range(0, 400);
            for (int c = 0; c < n; c++) begin
                start = ($urandom_range(0, 15) == 0);
                tick();
            end
            start = 0;
            stop = 1;
            repeat ($urandom_range(1, 3)) tick();
            stop = 0;
            stop_all("rnd_stop_timeout");
        end
        spur_en = 0;

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
